fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage plus the IF/ID pipeline register of the P5 five-stage MIPS pipeline.
- Owns the program counter, drives the instruction-memory read address, and computes the next PC from the D-stage redirect decode (beq/jal/jr).
- Registers the fetched instruction and its PC into the D stage, where they feed the instruction decoder.
- Branch-delay-slot semantics: the instruction fetched behind a control-transfer is always passed to D, never flushed.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset; also the base address of instruction memory.
- IM_AW, 12, instruction-memory word-address width (4096 words).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- stall  input  1  from hazard unit; holds F_PC and the IF/ID register
- D_branch  input  1  D-stage instruction is beq
- D_cmp_eq  input  1  forwarded rs==rt comparison result in D
- D_jal  input  1  D-stage instruction is jal
- D_jr  input  1  D-stage instruction is jr
- D_rs_data  input  32  forwarded rs value in D (jr target)
- im_addr  output  IM_AW  instruction-memory word address
- im_rdata  input  32  instruction word; combinational read of im_addr
- F_PC  output  32  current fetch PC
- D_instr  output  32  IF/ID instruction register
- D_PC  output  32  IF/ID PC register
- D_npc_redirect  output  1  a redirect target is selected this cycle (debug/trace)

Behaviour:
- Clock and reset: one clock, clk, rising edge. Reset is synchronous and active-high, named reset.
- Reset values: F_PC=RESET_PC, D_instr=32'h0 (nop), D_PC=RESET_PC. Reset overrides stall.
- Instruction-memory address: im_addr = (F_PC - RESET_PC)[IM_AW+1:2]. Purely combinational. Addresses beyond the depth wrap modulo 2^IM_AW.
- Next-PC selection (combinational, all fields taken from D_instr and D_PC):
  - branch_taken = D_branch & D_cmp_eq.
  - Priority 1, branch_taken: npc = D_PC + 4 + (sign-extended imm16 << 2). Arithmetic is 32-bit; overflow wraps.
  - Priority 2, D_jal: npc = {D_PC[31:28], D_instr[25:0], 2'b00}.
  - Priority 3, D_jr: npc = {D_rs_data[31:2], 2'b00}. The low two bits are forced to zero.
  - Otherwise: npc = F_PC + 4.
  - D_npc_redirect = branch_taken | D_jal | D_jr.
- Register update on each rising edge with reset=0:
  - stall=1: F_PC, D_instr and D_PC hold their values. The redirect is ignored this cycle; it is re-evaluated next cycle because D is unchanged.
  - stall=0: F_PC <= npc; D_instr <= im_rdata; D_PC <= F_PC.
- Delay slot: when a redirect is taken, the instruction at D_PC+4 (currently in F) still advances into D. No flush or bubble is generated by this block.
- Latency:
  - An instruction appears on D_instr exactly one cycle after its PC is on F_PC, with no stall.
  - A redirect resolved in D takes effect on F_PC at the next edge: one delay-slot instruction, zero penalty beyond it.
- Simultaneous events:
  - Multiple redirect flags active at once: the priority above applies.
  - stall asserted together with a redirect: stall wins.
  - reset asserted mid-stall or mid-redirect: all registers return to reset values on that edge.
- No combinational path from im_rdata to F_PC or im_addr.

Test Plan:
- Reset then 4 free-running cycles: F_PC goes 0x3000, 0x3004, 0x3008, 0x300C. D_PC lags by one cycle. D_instr=0 in the first cycle after reset.
- beq taken: D_PC=0x3004, imm16=0xFFFE, D_branch=1, D_cmp_eq=1 -> next F_PC=0x3000. The delay-slot instruction at 0x3008 reaches D_instr.
- beq not taken (D_cmp_eq=0): F_PC increments by 4 normally and D_npc_redirect=0.
- jal with index 26'h0000C10 at D_PC=0x3010 -> F_PC=0x00003040. jr with D_rs_data=0x0000_3023 -> F_PC=0x3020.
- stall held for 3 cycles while D_jal=1: F_PC, D_PC and D_instr stay constant. Release stall -> F_PC=jal target on the next edge.
- reset asserted during stall with D_branch=1 -> F_PC=0x3000, D_instr=0 on that edge. Branch and jal both asserted -> the branch target wins.

Source files
------------

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory read bus between the fetch stage and instruction memory
interface fetch_stage_if #(parameter int IM_AW = 12);
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      im_rdata;
  modport master(output im_addr, input im_rdata);
  modport slave(input im_addr, output im_rdata);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage with PC, next-PC redirect select and IF/ID register
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_AW    = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                D_branch,
  input  logic                D_cmp_eq,
  input  logic                D_jal,
  input  logic                D_jr,
  input  logic [31:0]         D_rs_data,
  fetch_stage_if.master       im,
  output logic [31:0]         F_PC,
  output logic [31:0]         D_instr,
  output logic [31:0]         D_PC,
  output logic                D_npc_redirect
);
  logic [31:0] r_f_pc, r_d_instr, r_d_pc;
  logic [31:0] w_npc, w_imm, w_jr;
  logic        w_taken;
  // PC is always word aligned and RESET_PC is the memory base, so no borrow crosses bit 2
  assign im.im_addr     = r_f_pc[IM_AW+1:2] - RESET_PC[IM_AW+1:2];
  assign w_taken        = D_branch & D_cmp_eq;
  assign w_imm          = {{14{r_d_instr[15]}}, r_d_instr[15:0], 2'b00};
  assign w_jr           = D_rs_data & ~32'h3;
  assign D_npc_redirect = w_taken | D_jal | D_jr;
  assign F_PC           = r_f_pc;
  assign D_instr        = r_d_instr;
  assign D_PC           = r_d_pc;
  // next PC: branch over jal over jr over sequential fetch
  always_comb
    w_npc = w_taken ? r_d_pc + 32'd4 + w_imm :
            D_jal   ? {r_d_pc[31:28], r_d_instr[25:0], 2'b00} :
            D_jr    ? w_jr : r_f_pc + 32'd4;
  // PC and IF/ID register; stall freezes both so the redirect is re-evaluated next cycle
  always_ff @(posedge clk)
    if (reset) begin
      r_f_pc    <= RESET_PC;
      r_d_instr <= 32'h0;
      r_d_pc    <= RESET_PC;
    end else if (!stall) begin
      r_f_pc    <= w_npc;
      r_d_instr <= im.im_rdata;
      r_d_pc    <= r_f_pc;
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized and directed checks of fetch_stage against a behavioural model
module tb_fetch_stage;
  localparam logic [31:0] RP = 32'h0000_3000;
  logic clk = 0, reset = 0, stall = 0, D_branch = 0, D_cmp_eq = 0, D_jal = 0, D_jr = 0;
  logic [31:0] D_rs_data = 0, F_PC, D_instr, D_PC;
  logic D_npc_redirect;
  logic [31:0] mem [4096];
  logic [31:0] m_f, m_dpc, m_di;
  int n_cmp = 0, n_fail = 0;
  fetch_stage_if #(.IM_AW(12)) ifc ();
  assign ifc.im_rdata = mem[ifc.im_addr];
  fetch_stage #(.RESET_PC(RP), .IM_AW(12)) dut (
    .clk(clk), .reset(reset), .stall(stall), .D_branch(D_branch), .D_cmp_eq(D_cmp_eq),
    .D_jal(D_jal), .D_jr(D_jr), .D_rs_data(D_rs_data), .im(ifc.master),
    .F_PC(F_PC), .D_instr(D_instr), .D_PC(D_PC), .D_npc_redirect(D_npc_redirect));
  always #5 clk = ~clk;

  task automatic tick();
    logic [31:0] nf, ndpc, ndi;
    int off;
    if (reset) begin
      nf = RP; ndpc = RP; ndi = 0;
    end else if (stall) begin
      nf = m_f; ndpc = m_dpc; ndi = m_di;
    end else begin
      off = int'($signed(m_di[15:0]));
      if (D_branch && D_cmp_eq) nf = m_dpc + 4 + 32'(off * 4);
      else if (D_jal) nf = {m_dpc[31:28], m_di[25:0], 2'b00};
      else if (D_jr) nf = D_rs_data - (D_rs_data % 4);
      else nf = m_f + 4;
      ndi = mem[((m_f - RP) / 4) % 4096];
      ndpc = m_f;
    end
    @(posedge clk);
    m_f = nf; m_dpc = ndpc; m_di = ndi;
    #1;
  endtask

  task automatic clear_ctl();
    stall = 0; D_branch = 0; D_cmp_eq = 0; D_jal = 0; D_jr = 0; D_rs_data = 0;
  endtask

  task automatic do_reset();
    clear_ctl();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic test_reset();
    stall = 1; D_jal = 1; reset = 1; tick(); reset = 0; clear_ctl();
    n_cmp++; if (F_PC !== RP) begin n_fail++; $display("FAIL reset_fpc got %h want %h", F_PC, RP); end
    n_cmp++; if (D_PC !== RP) begin n_fail++; $display("FAIL reset_dpc got %h want %h", D_PC, RP); end
    n_cmp++; if (D_instr !== 32'h0) begin n_fail++; $display("FAIL reset_dinstr got %h want 0", D_instr); end
    n_cmp++; if (ifc.im_addr !== 12'h0) begin n_fail++; $display("FAIL reset_imaddr got %h want 0", ifc.im_addr); end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++; if (F_PC !== RP + 32'(4 * i)) begin n_fail++; $display("FAIL seq_fpc got %h want %h", F_PC, RP + 32'(4 * i)); end
      n_cmp++; if (D_PC !== RP + 32'(4 * (i - 1))) begin n_fail++; $display("FAIL seq_dpc got %h want %h", D_PC, RP + 32'(4 * (i - 1))); end
      n_cmp++; if (D_instr !== mem[i - 1]) begin n_fail++; $display("FAIL seq_dinstr got %h want %h", D_instr, mem[i - 1]); end
    end
  endtask

  task automatic test_beq();
    mem[1] = {16'h1000, 16'hFFFE};
    do_reset(); tick(); tick();
    D_branch = 1; D_cmp_eq = 0; #1;
    n_cmp++; if (D_npc_redirect !== 1'b0) begin n_fail++; $display("FAIL beq_nt_redirect got %b want 0", D_npc_redirect); end
    tick();
    n_cmp++; if (F_PC !== 32'h300C) begin n_fail++; $display("FAIL beq_nt_fpc got %h want 0000300c", F_PC); end
    do_reset(); tick(); tick();
    D_branch = 1; D_cmp_eq = 1; #1;
    n_cmp++; if (D_npc_redirect !== 1'b1) begin n_fail++; $display("FAIL beq_t_redirect got %b want 1", D_npc_redirect); end
    tick(); clear_ctl();
    n_cmp++; if (F_PC !== 32'h3000) begin n_fail++; $display("FAIL beq_t_fpc got %h want 00003000", F_PC); end
    n_cmp++; if (D_instr !== mem[2] || D_PC !== 32'h3008) begin n_fail++; $display("FAIL beq_delay_slot got %h@%h want %h@00003008", D_instr, D_PC, mem[2]); end
  endtask

  task automatic test_jal_jr();
    mem[4] = {6'b000011, 26'h0000C10};
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    D_jal = 1; tick(); D_jal = 0;
    n_cmp++; if (F_PC !== 32'h3040) begin n_fail++; $display("FAIL jal_fpc got %h want 00003040", F_PC); end
    D_jr = 1; D_rs_data = 32'h3023; tick(); clear_ctl();
    n_cmp++; if (F_PC !== 32'h3020) begin n_fail++; $display("FAIL jr_fpc got %h want 00003020", F_PC); end
  endtask

  task automatic test_stall();
    logic [31:0] f, dp, di;
    mem[4] = {6'b000011, 26'h0000C10};
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    f = F_PC; dp = D_PC; di = D_instr;
    D_jal = 1; stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (F_PC !== f || D_PC !== dp || D_instr !== di) begin n_fail++; $display("FAIL stall_hold got %h/%h/%h want %h/%h/%h", F_PC, D_PC, D_instr, f, dp, di); end
    end
    stall = 0; tick(); clear_ctl();
    n_cmp++; if (F_PC !== 32'h3040) begin n_fail++; $display("FAIL stall_release got %h want 00003040", F_PC); end
  endtask

  task automatic test_reset_mid_and_priority();
    mem[1] = {6'b000100, 10'h3FF, 16'hFFFE};
    do_reset(); tick(); tick();
    stall = 1; D_branch = 1; D_cmp_eq = 1; tick();
    reset = 1; tick(); reset = 0; clear_ctl();
    n_cmp++; if (F_PC !== RP || D_instr !== 32'h0) begin n_fail++; $display("FAIL reset_mid got %h/%h want %h/0", F_PC, D_instr, RP); end
    tick(); tick();
    D_branch = 1; D_cmp_eq = 1; D_jal = 1; D_jr = 1; D_rs_data = 32'h5555_5554; tick(); clear_ctl();
    n_cmp++; if (F_PC !== 32'h3000) begin n_fail++; $display("FAIL priority got %h want 00003000", F_PC); end
  endtask

  task automatic test_random();
    logic rd;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      D_branch = $urandom_range(0, 1); D_cmp_eq = $urandom_range(0, 1);
      D_jal = ($urandom_range(0, 5) == 0); D_jr = ($urandom_range(0, 7) == 0);
      D_rs_data = RP + ($urandom_range(0, 8191) << 0);
      reset = ($urandom_range(0, 50) == 0);
      rd = (D_branch && D_cmp_eq) || D_jal || D_jr;
      #1;
      n_cmp++; if (D_npc_redirect !== rd) begin n_fail++; $display("FAIL rnd_redirect got %b want %b", D_npc_redirect, rd); end
      n_cmp++; if (ifc.im_addr !== 12'(((m_f - RP) / 4) % 4096)) begin n_fail++; $display("FAIL rnd_imaddr got %h want %h", ifc.im_addr, 12'(((m_f - RP) / 4) % 4096)); end
      tick(); reset = 0;
      n_cmp++; if (F_PC !== m_f) begin n_fail++; $display("FAIL rnd_fpc got %h want %h", F_PC, m_f); end
      n_cmp++; if (D_PC !== m_dpc) begin n_fail++; $display("FAIL rnd_dpc got %h want %h", D_PC, m_dpc); end
      n_cmp++; if (D_instr !== m_di) begin n_fail++; $display("FAIL rnd_dinstr got %h want %h", D_instr, m_di); end
    end
    clear_ctl();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    m_f = 0; m_dpc = 0; m_di = 0;
    #1;
    test_reset();
    test_sequential();
    test_beq();
    test_jal_jr();
    test_stall();
    test_reset_mid_and_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
